serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: adds two WIDTH-bit operands one bit per clock, LSB first,
// and presents the registered sum/carry with a one-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;

  logic             bit_s;
  logic             carry_nx;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    c_out_d  = c_out_q;

    bit_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_nx  = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at index 0.
    res_shift = res_sh_q >> 1;
    res_shift[WIDTH-1] = bit_s;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = c_in;
          cnt_d    = '0;
          res_sh_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = carry_nx;
        res_sh_d = res_shift;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          sum_d   = res_shift;
          c_out_d = carry_nx;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      c_out_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      c_out_q  <= c_out_d;
    end
  end

  // Decoded straight from the state flop so reset clears them without waiting for a clock.
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule
